// File: rtl/kgp_mc_sequencer.sv
// Multi-cycle control sequencer: fetch/decode/exec/mem/wb FSM with debug hold and halt.
// Optional saturating performance counters are built only when PERF_CNT_EN is defined.
module kgp_mc_sequencer #(
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hld,
  input  logic [ADDR_W-1:0] addr_fpga,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              reg_write,
  input  logic              halt,
  output logic              pc_en,
  output logic              ir_en,
  output logic              regwrite_en,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              hold_ack,
  output logic              halted,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  instr_cnt
);

  typedef enum logic [2:0] {
    StFetch, StDecode, StExec, StMem, StWb, StHold, StHalt
  } state_e;

  localparam logic [2:0] LatLast    = 3'(MEM_LAT);
  localparam logic [2:0] LatMemLast = 3'(MEM_LAT - 1);

  state_e     state_q, state_d;
  logic [2:0] lat_q, lat_d;
  logic       store_q, store_d;
  logic       pc_en_q, pc_en_d;
  logic       ir_en_q, ir_en_d;
  logic       regwrite_en_q, regwrite_en_d;
  logic       mem_en_q, mem_en_d;
  logic       mem_we_q, mem_we_d;
  logic       hold_ack_q, hold_ack_d;
  logic       halted_q, halted_d;

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    store_d = store_q;
    unique case (state_q)
      StFetch: begin
        // Hold is only honoured at fetch entry so an instruction never splits.
        if (lat_q == 3'd0 && hld) begin
          state_d = StHold;
        end else if (lat_q == LatLast) begin
          state_d = StDecode;
          lat_d   = 3'd0;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      StDecode: state_d = StExec;
      StExec: begin
        if (halt) begin
          state_d = StHalt;
        end else if (mem_read || mem_write) begin
          state_d = StMem;
          store_d = mem_write;
          lat_d   = 3'd0;
        end else if (reg_write) begin
          state_d = StWb;
        end else begin
          state_d = StFetch;
        end
      end
      StMem: begin
        if (lat_q == LatMemLast) begin
          lat_d   = 3'd0;
          state_d = store_q ? StFetch : StWb;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      StWb:    state_d = StFetch;
      StHold:  if (!hld) state_d = StFetch;
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  // Outputs are decoded from the next state so the registered strobes line up with it.
  always_comb begin
    ir_en_d       = (state_d == StFetch) && (lat_d == LatLast);
    pc_en_d       = (state_d == StExec);
    regwrite_en_d = (state_d == StWb);
    mem_we_d      = (state_d == StMem) && (lat_d == 3'd0) && store_d;
    hold_ack_d    = (state_d == StHold) || ((state_d == StHalt) && hld);
    mem_en_d      = (state_d == StMem) || hold_ack_d;
    halted_d      = (state_d == StHalt);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StFetch;
      lat_q         <= 3'd0;
      store_q       <= 1'b0;
      pc_en_q       <= 1'b0;
      ir_en_q       <= 1'b0;
      regwrite_en_q <= 1'b0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      hold_ack_q    <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      lat_q         <= lat_d;
      store_q       <= store_d;
      pc_en_q       <= pc_en_d;
      ir_en_q       <= ir_en_d;
      regwrite_en_q <= regwrite_en_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      hold_ack_q    <= hold_ack_d;
      halted_q      <= halted_d;
    end
  end

  assign pc_en       = pc_en_q;
  assign ir_en       = ir_en_q;
  assign regwrite_en = regwrite_en_q;
  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign hold_ack    = hold_ack_q;
  assign halted      = halted_q;
  assign bram_addr   = hold_ack_q ? addr_fpga : alu_addr;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    instr_cnt_d = instr_cnt_q;
    if (state_q != StHold && cycle_cnt_q != '1) cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
    if (pc_en_q && instr_cnt_q != '1) instr_cnt_d = instr_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule
